// File: rtl/mux_stream_rr_pkg.sv
// Shared definitions for the stream multiplexer family: width helpers,
// grant-mode encodings and the output buffer state type.
package mux_pkg;

  localparam int FP_W = 32;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Select / channel-ID width; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_stream_rr_if.sv
// Bundle of the N input streams, grant controls and the merged output stream.
interface mux_stream_rr_if import mux_pkg::*; #(
  parameter int N_CH = 4,
  parameter int W    = FP_W
);
  localparam int SEL_W = sel_width(N_CH);

  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_ready;

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/mux_stream_rr_arb.sv
// Combinational round-robin arbiter: rotate requests so the search starts
// just after ptr, priority-encode the lowest set bit, then unrotate.
module rr_arbiter import mux_pkg::*; #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   NCH_W = (SEL_W + 1)'(N_CH);

  logic [SEL_W-1:0] w_start;
  logic [N_CH-1:0]  w_rot;
  logic [SEL_W-1:0] w_pos;
  logic [SEL_W:0]   w_sum;

  // Explicit wrap keeps non-power-of-two channel counts correct.
  assign w_start = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign w_rot   = N_CH'({req, req} >> w_start);

  always_comb begin
    w_pos = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (w_rot[j]) w_pos = SEL_W'(j);
    end
  end

  assign w_sum   = {1'b0, w_start} + {1'b0, w_pos};
  assign gnt_idx = (w_sum >= NCH_W) ? SEL_W'(w_sum - NCH_W) : w_sum[SEL_W-1:0];
  assign gnt_vld = |req;

endmodule

// File: rtl/mux_stream_rr.sv
// N-to-1 stream mux with a one-entry registered output buffer and either
// externally selected or round-robin grants.
module mux_stream_rr import mux_pkg::*; #(
  parameter int N_CH = 4,
  parameter int W    = FP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_stream_rr_if.slave bus
);

  localparam int              SEL_W = sel_width(N_CH);
  localparam logic [N_CH-1:0] ONE   = N_CH'(1);

  buf_state_e       r_state, w_state_nxt;
  logic [W-1:0]     r_data_p1;
  logic [SEL_W-1:0] r_ch_p1;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load;
  logic [N_CH-1:0]  w_sel_onehot;
  logic             w_sel_vld;
  logic [SEL_W-1:0] w_arb_idx;
  logic             w_arb_vld;
  logic [SEL_W-1:0] w_gnt;
  logic             w_gnt_vld;
  logic             w_xfer;
  logic [W-1:0]     w_gnt_data;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_vld (w_arb_vld)
  );

  assign w_load = (r_state == BUF_EMPTY) || bus.out_ready;

  // A select beyond the last channel shifts the one-hot out entirely: no grant.
  assign w_sel_onehot = ONE << bus.sel;
  assign w_sel_vld    = |(bus.in_valid & w_sel_onehot);

  assign w_gnt     = (bus.mode == MODE_RR) ? w_arb_idx : bus.sel;
  assign w_gnt_vld = (bus.mode == MODE_RR) ? w_arb_vld : w_sel_vld;

  // rst_n gating holds every ready low while reset is asserted.
  assign w_xfer       = rst_n && w_load && w_gnt_vld;
  assign bus.in_ready = w_xfer ? (ONE << w_gnt) : '0;

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt == SEL_W'(i)) w_gnt_data = bus.in_data[i*W +: W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) w_state_nxt = w_xfer ? BUF_FULL : BUF_EMPTY;
  end

  // Stage p1: output buffer and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1 <= '0;
      r_ch_p1   <= '0;
      r_ptr     <= SEL_W'(N_CH - 1);
    end else if (w_xfer) begin
      r_data_p1 <= w_gnt_data;
      r_ch_p1   <= w_gnt;
      r_ptr     <= w_gnt;
    end
  end

  assign bus.out_valid = (r_state == BUF_FULL);
  assign bus.out_data  = r_data_p1;
  assign bus.out_ch    = r_ch_p1;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed bench for mux_stream_rr: a 4-channel instance and a 3-channel
// instance sharing clock and reset.
module tb_mux_stream_rr;
  import mux_pkg::*;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  mux_stream_rr_if #(.N_CH(4), .W(32)) bus_a ();
  mux_stream_rr_if #(.N_CH(3), .W(32)) bus_b ();

  mux_stream_rr #(.N_CH(4), .W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_stream_rr #(.N_CH(3), .W(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_a.in_valid = '0;
    bus_b.in_valid = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.mode = MODE_RR;
    bus_a.in_valid = 4'b1111;
    bus_a.out_ready = 1'b1;
    #2;
    nvec++; if (bus_a.in_ready !== 4'b0000) begin nerr++; $display("FAIL reset_ready got %b want 0000", bus_a.in_ready); end
    nvec++; if (bus_a.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", bus_a.out_valid); end
    nvec++; if (bus_a.out_data !== 32'h0) begin nerr++; $display("FAIL reset_data got %h want 0", bus_a.out_data); end
    nvec++; if (bus_a.out_ch !== 2'd0) begin nerr++; $display("FAIL reset_ch got %0d want 0", bus_a.out_ch); end
    nvec++; if (bus_b.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid_b got %b want 0", bus_b.out_valid); end
    step();
  endtask

  task automatic test_sel();
    do_reset();
    bus_a.mode = MODE_SEL;
    bus_a.sel = 2'd2;
    bus_a.out_ready = 1'b1;
    bus_a.in_data = {32'h11111111, 32'h3F800000, 32'h22222222, 32'h33333333};
    bus_a.in_valid = 4'b0100;
    #1;
    nvec++; if (bus_a.in_ready !== 4'b0100) begin nerr++; $display("FAIL sel_ready got %b want 0100", bus_a.in_ready); end
    step();
    bus_a.in_valid = 4'b0000;
    nvec++; if (bus_a.out_valid !== 1'b1) begin nerr++; $display("FAIL sel_valid got %b want 1", bus_a.out_valid); end
    nvec++; if (bus_a.out_data !== 32'h3F800000) begin nerr++; $display("FAIL sel_data got %h want 3f800000", bus_a.out_data); end
    nvec++; if (bus_a.out_ch !== 2'd2) begin nerr++; $display("FAIL sel_ch got %0d want 2", bus_a.out_ch); end
    step();
    nvec++; if (bus_a.out_valid !== 1'b0) begin nerr++; $display("FAIL sel_drain got %b want 0", bus_a.out_valid); end
  endtask

  task automatic test_rr_all();
    logic [1:0] exp_ch;
    do_reset();
    bus_a.mode = MODE_RR;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus_a.in_data[i*32 +: 32] = 32'hA0 + i;
    bus_a.in_valid = 4'b1111;
    #1;
    nvec++; if (bus_a.in_ready !== 4'b0001) begin nerr++; $display("FAIL rr_first_ready got %b want 0001", bus_a.in_ready); end
    for (int i = 0; i < 8; i++) begin
      step();
      exp_ch = 2'(i % 4);
      nvec++; if (bus_a.out_valid !== 1'b1) begin nerr++; $display("FAIL rr_valid[%0d] got %b want 1", i, bus_a.out_valid); end
      nvec++; if (bus_a.out_ch !== exp_ch) begin nerr++; $display("FAIL rr_ch[%0d] got %0d want %0d", i, bus_a.out_ch, exp_ch); end
      nvec++; if (bus_a.out_data !== 32'hA0 + 32'(exp_ch)) begin nerr++; $display("FAIL rr_data[%0d] got %h want %h", i, bus_a.out_data, 32'hA0 + 32'(exp_ch)); end
    end
  endtask

  // Entered with the buffer holding channel 3's word.
  task automatic test_backpressure();
    bus_a.out_ready = 1'b0;
    #1;
    nvec++; if (bus_a.in_ready !== 4'b0000) begin nerr++; $display("FAIL bp_ready0 got %b want 0000", bus_a.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (bus_a.in_ready !== 4'b0000) begin nerr++; $display("FAIL bp_ready[%0d] got %b want 0000", i, bus_a.in_ready); end
      nvec++; if (bus_a.out_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus_a.out_valid); end
      nvec++; if (bus_a.out_ch !== 2'd3) begin nerr++; $display("FAIL bp_ch[%0d] got %0d want 3", i, bus_a.out_ch); end
      nvec++; if (bus_a.out_data !== 32'hA3) begin nerr++; $display("FAIL bp_data[%0d] got %h want a3", i, bus_a.out_data); end
    end
    bus_a.out_ready = 1'b1;
    #1;
    nvec++; if (bus_a.in_ready !== 4'b0001) begin nerr++; $display("FAIL bp_release_ready got %b want 0001", bus_a.in_ready); end
    step();
    nvec++; if (bus_a.out_valid !== 1'b1) begin nerr++; $display("FAIL bp_refill_valid got %b want 1", bus_a.out_valid); end
    nvec++; if (bus_a.out_ch !== 2'd0) begin nerr++; $display("FAIL bp_refill_ch got %0d want 0", bus_a.out_ch); end
    nvec++; if (bus_a.out_data !== 32'hA0) begin nerr++; $display("FAIL bp_refill_data got %h want a0", bus_a.out_data); end
  endtask

  task automatic test_rr_pair();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd0, 2'd3, 2'd0, 2'd3};
    do_reset();
    bus_a.mode = MODE_RR;
    bus_a.out_ready = 1'b1;
    bus_a.in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++; if (bus_a.out_ch !== exp_seq[i]) begin nerr++; $display("FAIL pair_ch[%0d] got %0d want %0d", i, bus_a.out_ch, exp_seq[i]); end
    end
    bus_a.in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (bus_a.out_ch !== 2'd3) begin nerr++; $display("FAIL solo_ch[%0d] got %0d want 3", i, bus_a.out_ch); end
      nvec++; if (bus_a.out_valid !== 1'b1) begin nerr++; $display("FAIL solo_valid[%0d] got %b want 1", i, bus_a.out_valid); end
    end
  endtask

  task automatic test_sel_oob();
    do_reset();
    bus_b.mode = MODE_SEL;
    bus_b.sel = 2'd3;
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) bus_b.in_data[i*32 +: 32] = 32'hB0 + i;
    bus_b.in_valid = 3'b111;
    #1;
    nvec++; if (bus_b.in_ready !== 3'b000) begin nerr++; $display("FAIL oob_ready got %b want 000", bus_b.in_ready); end
    step();
    nvec++; if (bus_b.out_valid !== 1'b0) begin nerr++; $display("FAIL oob_valid got %b want 0", bus_b.out_valid); end
    bus_b.sel = 2'd1;
    #1;
    nvec++; if (bus_b.in_ready !== 3'b010) begin nerr++; $display("FAIL oob_sel1_ready got %b want 010", bus_b.in_ready); end
    step();
    nvec++; if (bus_b.out_valid !== 1'b1) begin nerr++; $display("FAIL oob_sel1_valid got %b want 1", bus_b.out_valid); end
    nvec++; if (bus_b.out_ch !== 2'd1) begin nerr++; $display("FAIL oob_sel1_ch got %0d want 1", bus_b.out_ch); end
    nvec++; if (bus_b.out_data !== 32'hB1) begin nerr++; $display("FAIL oob_sel1_data got %h want b1", bus_b.out_data); end
    bus_b.in_valid = 3'b000;
  endtask

  task automatic test_async_reset();
    bus_a.mode = MODE_RR;
    bus_a.out_ready = 1'b1;
    bus_a.in_valid = 4'b1111;
    step();
    nvec++; if (bus_a.out_valid !== 1'b1) begin nerr++; $display("FAIL ar_full got %b want 1", bus_a.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++; if (bus_a.out_valid !== 1'b0) begin nerr++; $display("FAIL ar_valid got %b want 0", bus_a.out_valid); end
    nvec++; if (bus_a.out_data !== 32'h0) begin nerr++; $display("FAIL ar_data got %h want 0", bus_a.out_data); end
    nvec++; if (bus_a.in_ready !== 4'b0000) begin nerr++; $display("FAIL ar_ready got %b want 0000", bus_a.in_ready); end
    rst_n = 1'b1;
    #1;
    nvec++; if (bus_a.in_ready !== 4'b0001) begin nerr++; $display("FAIL ar_first_ready got %b want 0001", bus_a.in_ready); end
    step();
    nvec++; if (bus_a.out_ch !== 2'd0) begin nerr++; $display("FAIL ar_first_ch got %0d want 0", bus_a.out_ch); end
    nvec++; if (bus_a.out_data !== 32'hA0) begin nerr++; $display("FAIL ar_first_data got %h want a0", bus_a.out_data); end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus_a.mode = MODE_SEL;
    bus_a.sel = '0;
    bus_a.in_valid = '0;
    bus_a.in_data = '0;
    bus_a.out_ready = 1'b0;
    bus_b.mode = MODE_SEL;
    bus_b.sel = '0;
    bus_b.in_valid = '0;
    bus_b.in_data = '0;
    bus_b.out_ready = 1'b0;
    #1;
    test_reset();
    test_sel();
    test_rr_all();
    test_backpressure();
    test_rr_pair();
    test_sel_oob();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
